// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC register, next-PC selection, IF/ID pipeline register.
// The ROM read is combinational; IF/ID captures it on the next edge.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        jump_en,
  input  logic [25:0] jump_index,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  input  logic [31:0] Instruction,
  output logic [30:0] Address,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        jr_take;
  logic        jump_take;
  logic        redirect;
  logic        bubble;
  logic        load;

  assign pc_plus4  = pc + 32'd4;
  assign Address   = pc[30:0];

  // ID redirects wait out a stall; the EX branch is older and wins
  assign jr_take   = jr_en & ~stall;
  assign jump_take = jump_en & ~stall;
  assign redirect  = branch_en | jr_take | jump_take;
  assign bubble    = redirect | flush;
  assign load      = ~bubble & ~stall;

  always_comb begin
    next_pc = pc_plus4;
    priority case (1'b1)
      branch_en: next_pc = branch_target;
      jr_take:   next_pc = {jr_target[31:2], 2'b00};
      jump_take: next_pc = {ifid_pc_plus4[31:28], jump_index, 2'b00};
      stall:     next_pc = pc;
      default:   next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_instr    <= NOP;
      ifid_pc_plus4 <= 32'd0;
      ifid_valid    <= 1'b0;
      fetch_count   <= 32'd0;
    end else if (bubble) begin
      ifid_instr    <= NOP;
      ifid_pc_plus4 <= 32'd0;
      ifid_valid    <= 1'b0;
    end else if (load) begin
      ifid_instr    <= Instruction;
      ifid_pc_plus4 <= pc_plus4;
      ifid_valid    <= 1'b1;
      fetch_count   <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small behavioural ROM.
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        jump_en;
  logic [25:0] jump_index;
  logic        jr_en;
  logic [31:0] jr_target;
  logic        branch_en;
  logic [31:0] branch_target;
  logic [31:0] Instruction;
  logic [30:0] Address;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  logic [31:0] rom [256];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign Instruction = rom[Address[9:2]];

  instruction_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .jump_en       (jump_en),
    .jump_index    (jump_index),
    .jr_en         (jr_en),
    .jr_target     (jr_target),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .Instruction   (Instruction),
    .Address       (Address),
    .pc            (pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid),
    .fetch_count   (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic state(input string tag, input logic [31:0] e_pc,
                       input logic [31:0] e_instr, input logic [31:0] e_p4,
                       input logic e_valid, input logic [31:0] e_fc);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".addr"}, {1'b0, Address}, {1'b0, e_pc[30:0]});
    chk({tag, ".instr"}, ifid_instr, e_instr);
    chk({tag, ".p4"}, ifid_pc_plus4, e_p4);
    chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, e_valid});
    chk({tag, ".fc"}, fetch_count, e_fc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; flush = 0; jump_en = 0; jr_en = 0; branch_en = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h1000_0000 + i;
    rom[0] = 32'h0800_0003;
    rom[1] = 32'h0c00_0015;
    rom[2] = 32'h0800_0016;
    rom[3] = 32'h2004_0003;
    idle();
    jump_index = '0; jr_target = '0; branch_target = '0;
    reset = 0;
    #2;
    state("rst", 32'h0, 32'h0, 32'h0, 0, 0);
    #1 reset = 1;

    step(); state("f1", 32'h4, rom[0], 32'h4, 1, 1);
    step(); state("f2", 32'h8, rom[1], 32'h8, 1, 2);
    step(); state("f3", 32'hC, rom[2], 32'hC, 1, 3);

    jump_en = 1; jump_index = 26'h3;
    step(); state("jmp", 32'hC, 32'h0, 32'h0, 0, 3);
    idle();
    step(); state("jmp+1", 32'h10, 32'h2004_0003, 32'h10, 1, 4);
    step(); state("f5", 32'h14, rom[4], 32'h14, 1, 5);
    step(); state("f6", 32'h18, rom[5], 32'h18, 1, 6);

    stall = 1;
    step(); state("stl1", 32'h18, rom[5], 32'h18, 1, 6);
    step(); state("stl2", 32'h18, rom[5], 32'h18, 1, 6);
    idle();
    step(); state("stl.rel", 32'h1C, rom[6], 32'h1C, 1, 7);

    stall = 1; branch_en = 1; branch_target = 32'h14; jump_en = 1;
    step(); state("brstl", 32'h14, 32'h0, 32'h0, 0, 7);
    idle();
    step(); state("br+1", 32'h18, rom[5], 32'h18, 1, 8);

    jr_en = 1; jr_target = 32'h1B;
    step(); state("jr", 32'h18, 32'h0, 32'h0, 0, 8);
    idle();
    step(); state("jr+1", 32'h1C, rom[6], 32'h1C, 1, 9);

    flush = 1;
    step(); state("flush", 32'h20, 32'h0, 32'h0, 0, 9);
    idle();

    stall = 1; jump_en = 1; jump_index = 26'h3F; jr_en = 1;
    step(); state("stljmp", 32'h20, 32'h0, 32'h0, 0, 9);
    idle();

    branch_en = 1; branch_target = 32'hFFFF_FFFC;
    step(); state("brhi", 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 9);
    idle();
    step(); state("wrap", 32'h0, rom[255], 32'h0, 1, 10);

    branch_en = 1; branch_target = 32'hF000_0000;
    step(); state("brF", 32'hF000_0000, 32'h0, 32'h0, 0, 10);
    idle();
    step(); state("brF+1", 32'hF000_0004, rom[0], 32'hF000_0004, 1, 11);
    jump_en = 1; jump_index = 26'h3;
    step(); state("jmphi", 32'hF000_000C, 32'h0, 32'h0, 0, 11);
    idle();
    step(); state("jmphi+1", 32'hF000_0010, rom[3], 32'hF000_0010, 1, 12);

    branch_en = 1; branch_target = 32'h40;
    #2 reset = 0;
    #1 state("rst.mid", 32'h0, 32'h0, 32'h0, 0, 0);
    idle();
    #1 reset = 1;
    step(); state("rf1", 32'h4, rom[0], 32'h4, 1, 1);
    step(); state("rf2", 32'h8, rom[1], 32'h8, 1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
